// File: rtl/deser_pkg.sv
// Shared definitions for the LVDS DDR deserializer: link FSM states, default
// framing constants, and a small saturating-count helper.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HUNT_ZEROS = 2'd1,
    HUNT_SYNC  = 2'd2,
    LOCKED     = 2'd3
  } link_state_e;

  localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;
  localparam int unsigned DEF_ZERO_LEN  = 10;

  // Preamble zero counter advances two bits per pair and pins at 255.
  function automatic logic [7:0] sat_add2(input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, v} + 9'd2;
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/deser_sync_detect.sv
// Nine-bit receive shift register with both candidate byte windows (even and
// odd bit phase) and their sync-word compares, all taken from the post-shift value.
module deser_sync_detect
  import deser_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       shift_en,
  input  logic [1:0] in_data,
  output logic [7:0] w0,
  output logic [7:0] w1,
  output logic       match0,
  output logic       match1
);

  logic [8:0] sr_r;
  logic [8:0] sr_nxt_s;

  // Post-shift view: in_data[1] arrived first on the wire, so it lands above in_data[0].
  always_comb begin
    sr_nxt_s = {sr_r[6:0], in_data[1], in_data[0]};
  end

  assign w0     = sr_nxt_s[7:0];
  assign w1     = sr_nxt_s[8:1];
  assign match0 = (sr_nxt_s[7:0] == SYNC_WORD);
  assign match1 = (sr_nxt_s[8:1] == SYNC_WORD);

  // Shift register update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_r <= 9'd0;
    end else if (shift_en) begin
      sr_r <= sr_nxt_s;
    end else begin
      sr_r <= sr_r;
    end
  end

endmodule

// File: rtl/deser_link_ctrl.sv
// Link-training and framing controller: finds the zero-run preamble and sync
// byte at either bit phase, then emits aligned payload bytes and polices sync.
module deser_link_ctrl
  import deser_pkg::*;
#(
  parameter int unsigned ZERO_LEN     = DEF_ZERO_LEN,
  parameter logic [7:0]  SYNC_WORD    = DEF_SYNC_WORD,
  parameter int unsigned FRAME_LEN    = 64,
  parameter int unsigned MAX_ERR      = 3,
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0] ZERO_LEN_C  = 8'(ZERO_LEN);
  localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);
  localparam logic [3:0] MAX_ERR_C   = 4'(MAX_ERR);
  localparam logic [7:0] TMR_LAST_C  = 8'(SYNC_TIMEOUT - 1);

  link_state_e state_r, state_nxt_s;

  logic [7:0]  zero_cnt_r,    zero_cnt_nxt_s;
  logic [7:0]  sync_tmr_r,    sync_tmr_nxt_s;
  logic        phase_r,       phase_nxt_s;
  logic [1:0]  pair_cnt_r,    pair_cnt_nxt_s;
  logic [7:0]  byte_idx_r,    byte_idx_nxt_s;
  logic [3:0]  err_cnt_r,     err_cnt_nxt_s;
  logic [15:0] frame_cnt_r,   frame_cnt_nxt_s;
  logic [7:0]  out_data_r,    out_data_nxt_s;
  logic        out_valid_r,   out_valid_nxt_s;
  logic        frame_start_r, frame_start_nxt_s;
  logic        locked_r;
  logic        sync_err_r,    sync_err_nxt_s;

  logic        shift_en_s;
  logic [7:0]  w0_s, w1_s;
  logic        match0_s, match1_s;
  logic [7:0]  cur_byte_s;
  logic        cur_match_s;

  assign shift_en_s  = in_valid && (state_r != IDLE);
  assign cur_byte_s  = phase_r ? w1_s : w0_s;
  assign cur_match_s = phase_r ? match1_s : match0_s;

  deser_sync_detect #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detect (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (shift_en_s),
    .in_data  (in_data),
    .w0       (w0_s),
    .w1       (w1_s),
    .match0   (match0_s),
    .match1   (match1_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, counter and output decode; everything idles without in_valid.
  always_comb begin
    state_nxt_s       = state_r;
    zero_cnt_nxt_s    = zero_cnt_r;
    sync_tmr_nxt_s    = sync_tmr_r;
    phase_nxt_s       = phase_r;
    pair_cnt_nxt_s    = pair_cnt_r;
    byte_idx_nxt_s    = byte_idx_r;
    err_cnt_nxt_s     = err_cnt_r;
    frame_cnt_nxt_s   = frame_cnt_r;
    out_data_nxt_s    = out_data_r;
    out_valid_nxt_s   = 1'b0;
    frame_start_nxt_s = 1'b0;
    sync_err_nxt_s    = sync_err_r;

    if (!en) begin
      state_nxt_s    = IDLE;
      sync_err_nxt_s = 1'b0;
    end else if (in_valid) begin
      case (state_r)
        IDLE: begin
          state_nxt_s    = HUNT_ZEROS;
          zero_cnt_nxt_s = 8'd0;
        end
        HUNT_ZEROS: begin
          if (in_data == 2'b00) begin
            zero_cnt_nxt_s = sat_add2(zero_cnt_r);
          end else if (zero_cnt_r >= ZERO_LEN_C) begin
            state_nxt_s    = HUNT_SYNC;
            sync_tmr_nxt_s = 8'd0;
          end else begin
            zero_cnt_nxt_s = 8'd0;
          end
        end
        HUNT_SYNC: begin
          if (match0_s || match1_s) begin
            // Even phase wins when both windows hold the sync word.
            state_nxt_s     = LOCKED;
            phase_nxt_s     = !match0_s;
            pair_cnt_nxt_s  = 2'd0;
            byte_idx_nxt_s  = 8'd1;
            err_cnt_nxt_s   = 4'd0;
            frame_cnt_nxt_s = frame_cnt_r + 16'd1;
          end else if (sync_tmr_r == TMR_LAST_C) begin
            state_nxt_s    = HUNT_ZEROS;
            zero_cnt_nxt_s = 8'd0;
          end else begin
            sync_tmr_nxt_s = sync_tmr_r + 8'd1;
          end
        end
        LOCKED: begin
          pair_cnt_nxt_s = pair_cnt_r + 2'd1;
          if (pair_cnt_r != 2'd3) begin
            byte_idx_nxt_s = byte_idx_r;
          end else if (byte_idx_r == 8'd0) begin
            byte_idx_nxt_s = 8'd1;
            if (cur_match_s) begin
              err_cnt_nxt_s   = 4'd0;
              frame_cnt_nxt_s = frame_cnt_r + 16'd1;
            end else begin
              // Flywheel through isolated misses; give up after MAX_ERR in a row.
              err_cnt_nxt_s  = err_cnt_r + 4'd1;
              sync_err_nxt_s = 1'b1;
              if ((err_cnt_r + 4'd1) == MAX_ERR_C) begin
                state_nxt_s    = HUNT_ZEROS;
                zero_cnt_nxt_s = 8'd0;
              end else begin
                state_nxt_s = LOCKED;
              end
            end
          end else begin
            out_data_nxt_s    = cur_byte_s;
            out_valid_nxt_s   = 1'b1;
            frame_start_nxt_s = (byte_idx_r == 8'd1);
            byte_idx_nxt_s    = (byte_idx_r == FRAME_LEN_C) ? 8'd0 : (byte_idx_r + 8'd1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Datapath counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zero_cnt_r    <= 8'd0;
      sync_tmr_r    <= 8'd0;
      phase_r       <= 1'b0;
      pair_cnt_r    <= 2'd0;
      byte_idx_r    <= 8'd0;
      err_cnt_r     <= 4'd0;
      frame_cnt_r   <= 16'd0;
      out_data_r    <= 8'd0;
      out_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      locked_r      <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      zero_cnt_r    <= zero_cnt_nxt_s;
      sync_tmr_r    <= sync_tmr_nxt_s;
      phase_r       <= phase_nxt_s;
      pair_cnt_r    <= pair_cnt_nxt_s;
      byte_idx_r    <= byte_idx_nxt_s;
      err_cnt_r     <= err_cnt_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      out_data_r    <= out_data_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      locked_r      <= (state_nxt_s == LOCKED);
      sync_err_r    <= sync_err_nxt_s;
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign frame_start = frame_start_r;
  assign locked      = locked_r;
  assign sync_err    = sync_err_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: doc/deser_link_ctrl.md
Name: deser_link_ctrl

Overview:
- Link-training and framing controller for the LVDS DDR receive path.
- Consumes the 2-bit-per-clock pair stream from the DDR input stage.
- Hunts for the zero-run preamble, then finds the sync byte at either bit phase, and after lock delivers aligned payload bytes to the deserializer FIFO write side.
- Checks the sync byte at every frame boundary and drops lock after repeated mismatches.

Parameters:
- ZERO_LEN, 10: minimum consecutive zero bits that qualify as a preamble.
- SYNC_WORD, 8'hA5: sync byte, MSB first on the wire.
- FRAME_LEN, 64: payload bytes between sync bytes (1..255).
- MAX_ERR, 3: consecutive sync mismatches that cause loss of lock (1..15).
- SYNC_TIMEOUT, 64: pairs allowed in HUNT_SYNC before returning to HUNT_ZEROS.

Ports:
- clk, in, 1: clock (DDR pair rate).
- reset_n, in, 1: synchronous reset, active-low.
- en, in, 1: link enable; low forces IDLE.
- in_valid, in, 1: in_data valid this cycle.
- in_data, in, 2: bit pair; [1] is the earlier bit on the wire.
- out_data, out, 8: aligned payload byte.
- out_valid, out, 1: out_data valid; one-cycle pulse.
- frame_start, out, 1: asserted together with out_valid on payload byte 1 of each frame.
- locked, out, 1: state is LOCKED.
- sync_err, out, 1: sticky; set on any sync mismatch, cleared only by reset or by en low.
- frame_cnt, out, 16: count of good sync bytes; wraps at 16 bits.

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - state=IDLE; all outputs 0; internal shift register, counters and phase 0.
  - Reset mid-frame discards any partial byte.
- Shift register sr[8:0]:
  - On each in_valid cycle, sr <= {sr[6:0], in_data[1], in_data[0]}.
  - It shifts in every state except IDLE.
  - All actions below occur only on in_valid cycles. Without in_valid nothing changes, and out_valid and frame_start are 0.
- Candidate windows, computed from the post-shift value sr':
  - Phase 0 window: W0 = sr'[7:0].
  - Phase 1 window: W1 = sr'[8:1].
- IDLE:
  - If en=1, go to HUNT_ZEROS with zero_cnt=0.
- HUNT_ZEROS (zero_cnt is 8 bits, saturates at 255):
  - Pair 00: zero_cnt += 2.
  - Otherwise, if zero_cnt >= ZERO_LEN: go to HUNT_SYNC, sync_tmr=0. The current pair stays in sr.
  - Otherwise: zero_cnt=0.
- HUNT_SYNC:
  - If W0==SYNC_WORD: phase=0, go to LOCKED.
  - Else if W1==SYNC_WORD: phase=1, go to LOCKED.
  - W0 takes priority when both windows match.
  - Otherwise sync_tmr++. When sync_tmr reaches SYNC_TIMEOUT-1, go to HUNT_ZEROS with zero_cnt=0.
- Entry to LOCKED:
  - pair_cnt=0, byte_idx=1, err_cnt=0, frame_cnt++.
- LOCKED:
  - pair_cnt (2 bits) increments on each valid pair.
  - When pair_cnt==3 the byte is complete. byte = phase ? W1 : W0, and pair_cnt wraps to 0.
  - byte_idx 1..FRAME_LEN (payload bytes):
    - The next cycle shows out_data=byte and out_valid=1 (1-cycle registered latency).
    - frame_start=1 when byte_idx==1.
    - byte_idx increments; after FRAME_LEN it becomes 0.
  - byte_idx 0 (sync slot, never output):
    - Match: err_cnt=0, frame_cnt++.
    - Mismatch: err_cnt++ and sync_err=1. If err_cnt+1==MAX_ERR, go to HUNT_ZEROS with zero_cnt=0 and locked falls on that same clock edge.
    - byte_idx becomes 1 in both cases, so framing is flywheeled through errors below MAX_ERR.
- locked:
  - Registered; equals (state==LOCKED).
- en low in any state:
  - Next state is IDLE; locked and sync_err are cleared.
  - A pending out_valid still issues.
  - Reset has priority over en.
- Widths:
  - All counters wrap as unsigned except zero_cnt, which saturates.
  - frame_cnt wraps from 0xFFFF to 0x0000.

Decomposition:
- Package deser_pkg holds:
  - the state enum (IDLE, HUNT_ZEROS, HUNT_SYNC, LOCKED), 2 bits;
  - default SYNC_WORD and ZERO_LEN constants, shared with the deserializer FIFO.
- One sub-module, deser_sync_detect:
  - holds sr and produces W0 and W1 and the match flags;
  - purely registered shift plus compare.
- FSM and counters live in the top module.

Test Plan:
- 12 zero bits (6 pairs 00), then pairs 10,10,01,01 (A5, phase 0) -> locked rises after the 4th pair. Payload pairs for bytes 0x00..0x3F -> 64 out_valid pulses; the first carries frame_start and out_data 0x00, the last 0x3F. frame_cnt=1.
- Same preamble shifted one bit (sync straddles pairs) -> phase 1 selected, payload bytes identical to case 1.
- Preamble of only 8 zero bits, then A5 -> stays HUNT_ZEROS, locked=0, no out_valid.
- Locked link, corrupt sync byte to 0x5A in 3 consecutive frames (MAX_ERR=3) -> sync_err=1 after the first; frames 2 and 3 still emit 64 bytes each; locked=0 at the third sync slot; next valid preamble+sync relocks.
- Locked link, one bad sync then a good one -> err_cnt returns to 0, lock held, frame_cnt increments only on the good sync.
- Assert reset_n=0 for one cycle mid-payload (pair_cnt=2) -> next cycle: locked=0, out_valid=0, frame_cnt=0, state IDLE. Also en low mid-frame -> IDLE and sync_err cleared.
